// File: rtl/osc_clk_div_pkg.sv
// Shared types and constants for the oscillator clock-divider generator.
package osc_clk_div_pkg;

  // Default divide-ratio width and the widest ratio a pending request can carry.
  localparam int DIV_W_DEF = 16;
  localparam int DIV_W_MAX = 32;

  // Widest channel index a pending request can carry (up to 16 channels).
  localparam int CH_W_MAX = 4;

  // A ratio of zero parks the channel.
  localparam int DIV_DISABLED = 0;

  // One queued configuration request: target channel and new ratio.
  typedef struct packed {
    logic [CH_W_MAX-1:0]  ch;
    logic [DIV_W_MAX-1:0] div;
  } cfg_req_t;

  // Channel-index width, never narrower than one bit.
  function automatic int ch_w_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/osc_div_channel.sv
// One divider slice: ratio register, period counter and registered
// clock-enable / divided-clock / active outputs.
module osc_div_channel
  import osc_clk_div_pkg::*;
#(
  parameter int               DIV_W       = DIV_W_DEF,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             upd_req,
  input  logic [DIV_W-1:0] upd_div,
  output logic             upd_take,
  output logic             ce,
  output logic             div_clk,
  output logic             active
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             ce_q, ce_d;
  logic             dclk_q, dclk_d;
  logic             act_q, act_d;
  logic             enabled;
  logic             terminal;

  // Next counter/ratio; outputs are decoded from the next state so the
  // registered outputs line up with the counter value of the same cycle.
  always_comb begin
    enabled  = (div_q != DIV_W'(DIV_DISABLED));
    terminal = enabled && (cnt_q == div_q - DIV_W'(1));
    // A new ratio only lands on a period boundary, a restart, or an idle
    // channel, so no period is ever cut short or stretched.
    upd_take = upd_req && (restart || !enabled || terminal);
    div_d    = upd_take ? upd_div : div_q;
    if (restart || upd_take || !enabled || terminal) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
    act_d  = (div_d != DIV_W'(DIV_DISABLED));
    // D==1 falls out naturally: cnt stays 0 == D-1 and 0 < floor(1/2) is false.
    ce_d   = act_d && (cnt_d == div_d - DIV_W'(1));
    dclk_d = (cnt_d < (div_d >> 1));
  end

  // State and output registers with synchronous reset to the default ratio.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= DEFAULT_DIV;
      cnt_q  <= '0;
      ce_q   <= 1'b0;
      dclk_q <= 1'b0;
      act_q  <= (DEFAULT_DIV != DIV_W'(DIV_DISABLED));
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      ce_q   <= ce_d;
      dclk_q <= dclk_d;
      act_q  <= act_d;
    end
  end

  assign ce      = ce_q;
  assign div_clk = dclk_q;
  assign active  = act_q;

endmodule

// File: rtl/osc_clk_div_gen.sv
// Multi-channel clock-enable / divided-clock generator on the RC oscillator
// clock. Holds the single pending configuration slot and fans out SYNC.
module osc_clk_div_gen
  import osc_clk_div_pkg::*;
#(
  parameter int               NUM_CH      = 4,
  parameter int               DIV_W       = DIV_W_DEF,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(2),
  localparam int              CH_W        = ch_w_of(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CFG_VALID,
  output logic              CFG_READY,
  input  logic [CH_W-1:0]   CFG_CH,
  input  logic [DIV_W-1:0]  CFG_DIV,
  input  logic              SYNC,
  output logic [NUM_CH-1:0] CE_OUT,
  output logic [NUM_CH-1:0] DIV_CLK_OUT,
  output logic [NUM_CH-1:0] CH_ACTIVE
);

  cfg_req_t          pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic              ready_q, ready_d;
  logic              started_q, started_d;
  logic              accept;
  logic              in_range;
  logic              restart;
  logic [31:0]       ch_ext;
  logic [NUM_CH-1:0] take;
  logic              unused_pend;

  // Config slot: accept into the slot, clear it when its channel takes the
  // update, and keep READY low for the cycle the update is being applied.
  always_comb begin
    ch_ext      = 32'(CFG_CH);
    in_range    = (ch_ext < 32'(NUM_CH));
    accept      = CFG_VALID && ready_q;
    // The first cycle out of reset holds every counter at 0, like a SYNC.
    restart     = SYNC || !started_q;
    started_d   = 1'b1;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    if (pend_vld_q && (|take)) begin
      pend_vld_d = 1'b0;
    end
    // Requests for a channel that does not exist are swallowed silently.
    if (accept && in_range) begin
      pend_vld_d = 1'b1;
      pend_d.ch  = CH_W_MAX'(CFG_CH);
      pend_d.div = DIV_W_MAX'(CFG_DIV);
    end
    ready_d     = !pend_vld_q && !pend_vld_d;
    unused_pend = ^pend_q.div;
  end

  // Slot and handshake registers; reset discards any pending update.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ready_q    <= 1'b0;
      started_q  <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ready_q    <= ready_d;
      started_q  <= started_d;
    end
  end

  assign CFG_READY = ready_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    osc_div_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk      (CLK),
      .rst      (RESET),
      .restart  (restart),
      .upd_req  (pend_vld_q && (pend_q.ch == CH_W_MAX'(i))),
      .upd_div  (DIV_W'(pend_q.div)),
      .upd_take (take[i]),
      .ce       (CE_OUT[i]),
      .div_clk  (DIV_CLK_OUT[i]),
      .active   (CH_ACTIVE[i])
    );
  end

endmodule

// File: tb/tb_osc_clk_div_gen.sv
// Directed bench for osc_clk_div_gen (4 channels, 16-bit ratios, default 2).
module tb_osc_clk_div_gen;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        CFG_VALID;
  logic        CFG_READY;
  logic [1:0]  CFG_CH;
  logic [15:0] CFG_DIV;
  logic        SYNC;
  logic [3:0]  CE_OUT;
  logic [3:0]  DIV_CLK_OUT;
  logic [3:0]  CH_ACTIVE;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  osc_clk_div_gen #(
    .NUM_CH      (4),
    .DIV_W       (16),
    .DEFAULT_DIV (16'd2)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .CFG_VALID   (CFG_VALID),
    .CFG_READY   (CFG_READY),
    .CFG_CH      (CFG_CH),
    .CFG_DIV     (CFG_DIV),
    .SYNC        (SYNC),
    .CE_OUT      (CE_OUT),
    .DIV_CLK_OUT (DIV_CLK_OUT),
    .CH_ACTIVE   (CH_ACTIVE)
  );

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reset for two edges, release; returns in cycle 1 (all counters at 0).
  task automatic do_reset();
    RESET     = 1'b1;
    CFG_VALID = 1'b0;
    SYNC      = 1'b0;
    CFG_CH    = 2'd0;
    CFG_DIV   = 16'd0;
    step();
    step();
    RESET = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [3:0] exp_ce, exp_dc;
    RESET     = 1'b1;
    CFG_VALID = 1'b0;
    SYNC      = 1'b0;
    CFG_CH    = 2'd0;
    CFG_DIV   = 16'd0;
    step();
    step();
    checks++; if (CE_OUT !== 4'h0) begin errors++; $display("FAIL rst_ce got %b exp %b", CE_OUT, 4'h0); end
    checks++; if (DIV_CLK_OUT !== 4'h0) begin errors++; $display("FAIL rst_dclk got %b exp %b", DIV_CLK_OUT, 4'h0); end
    checks++; if (CFG_READY !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", CFG_READY); end
    checks++; if (CH_ACTIVE !== 4'hF) begin errors++; $display("FAIL rst_active got %b exp %b", CH_ACTIVE, 4'hF); end
    RESET = 1'b0;
    step();
    // Ratio 2 everywhere: CE on even cycles, divided clock high on odd cycles.
    for (int k = 1; k <= 20; k++) begin
      exp_ce = (k % 2 == 0) ? 4'hF : 4'h0;
      exp_dc = (k % 2 == 1) ? 4'hF : 4'h0;
      checks++; if (CE_OUT !== exp_ce) begin errors++; $display("FAIL dflt_ce cyc %0d got %b exp %b", k, CE_OUT, exp_ce); end
      checks++; if (DIV_CLK_OUT !== exp_dc) begin errors++; $display("FAIL dflt_dclk cyc %0d got %b exp %b", k, DIV_CLK_OUT, exp_dc); end
      checks++; if (CFG_READY !== 1'b1) begin errors++; $display("FAIL dflt_ready cyc %0d got %b exp 1", k, CFG_READY); end
      step();
    end
  endtask

  task automatic test_ratio_change();
    logic [3:0] exp_ce, exp_dc;
    logic       ev, ce1, dc1, exp_rdy;
    int         cnt;
    do_reset();
    CFG_VALID = 1'b1;
    CFG_CH    = 2'd1;
    CFG_DIV   = 16'd5;
    step();
    CFG_VALID = 1'b0;
    for (int c = 2; c <= 14; c++) begin
      ev = (c % 2 == 0);
      if (c == 2) begin
        ce1 = 1'b1;
        dc1 = 1'b0;
      end else begin
        cnt = (c - 3) % 5;
        ce1 = (cnt == 4);
        dc1 = (cnt < 2);
      end
      exp_ce  = {ev, ev, ce1, ev};
      exp_dc  = {!ev, !ev, dc1, !ev};
      exp_rdy = !(c == 2 || c == 3);
      checks++; if (CE_OUT !== exp_ce) begin errors++; $display("FAIL div5_ce cyc %0d got %b exp %b", c, CE_OUT, exp_ce); end
      checks++; if (DIV_CLK_OUT !== exp_dc) begin errors++; $display("FAIL div5_dclk cyc %0d got %b exp %b", c, DIV_CLK_OUT, exp_dc); end
      checks++; if (CFG_READY !== exp_rdy) begin errors++; $display("FAIL div5_ready cyc %0d got %b exp %b", c, CFG_READY, exp_rdy); end
      step();
    end
  endtask

  task automatic test_disable_enable();
    logic       exp_rdy;
    logic [3:0] exp_act, exp_ce, exp_dc;
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      exp_rdy = 1'b1; exp_act = 4'hF; exp_ce = 4'h0; exp_dc = 4'hF;
      case (c)
        2: begin exp_rdy = 1'b0; exp_act = 4'hF; exp_ce = 4'hF; exp_dc = 4'h0; end
        3: begin exp_rdy = 1'b0; exp_act = 4'hB; exp_ce = 4'h0; exp_dc = 4'hB; end
        4: begin exp_rdy = 1'b1; exp_act = 4'hB; exp_ce = 4'hB; exp_dc = 4'h0; end
        5: begin exp_rdy = 1'b0; exp_act = 4'hB; exp_ce = 4'h0; exp_dc = 4'hB; end
        6: begin exp_rdy = 1'b0; exp_act = 4'hF; exp_ce = 4'hB; exp_dc = 4'h4; end
        7: begin exp_rdy = 1'b1; exp_act = 4'hF; exp_ce = 4'h0; exp_dc = 4'hB; end
        8: begin exp_rdy = 1'b1; exp_act = 4'hF; exp_ce = 4'hF; exp_dc = 4'h0; end
        default: begin exp_rdy = 1'b1; exp_act = 4'hF; exp_ce = 4'h0; exp_dc = 4'hF; end
      endcase
      checks++; if (CH_ACTIVE !== exp_act) begin errors++; $display("FAIL dis_active cyc %0d got %b exp %b", c, CH_ACTIVE, exp_act); end
      checks++; if (CE_OUT !== exp_ce) begin errors++; $display("FAIL dis_ce cyc %0d got %b exp %b", c, CE_OUT, exp_ce); end
      checks++; if (DIV_CLK_OUT !== exp_dc) begin errors++; $display("FAIL dis_dclk cyc %0d got %b exp %b", c, DIV_CLK_OUT, exp_dc); end
      checks++; if (CFG_READY !== exp_rdy) begin errors++; $display("FAIL dis_ready cyc %0d got %b exp %b", c, CFG_READY, exp_rdy); end
      CFG_VALID = (c == 1 || c == 4);
      CFG_CH    = 2'd2;
      CFG_DIV   = (c == 4) ? 16'd3 : 16'd0;
      step();
    end
  endtask

  task automatic test_sync();
    logic [3:0] exp_ce, exp_dc;
    logic       ev;
    int         r;
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin
        checks++; if (CFG_READY !== 1'b0) begin errors++; $display("FAIL sync_ready3 got %b exp 0", CFG_READY); end
      end
      if (c == 8) begin
        checks++; if (CFG_READY !== 1'b1) begin errors++; $display("FAIL sync_ready8 got %b exp 1", CFG_READY); end
      end
      if (c >= 10 && c <= 17) begin
        r = c - 10;
        ev = (r % 2 == 0);
        exp_ce = {!ev, !ev, (r % 7 == 6), (r % 3 == 2)};
        exp_dc = {ev, ev, (r % 7 < 3), (r % 3 < 1)};
        checks++; if (CE_OUT !== exp_ce) begin errors++; $display("FAIL sync_ce cyc %0d got %b exp %b", c, CE_OUT, exp_ce); end
        checks++; if (DIV_CLK_OUT !== exp_dc) begin errors++; $display("FAIL sync_dclk cyc %0d got %b exp %b", c, DIV_CLK_OUT, exp_dc); end
      end
      if (c == 18 || c == 19) begin
        checks++; if (CE_OUT !== 4'h0) begin errors++; $display("FAIL synchold_ce cyc %0d got %b exp %b", c, CE_OUT, 4'h0); end
        checks++; if (DIV_CLK_OUT !== 4'hF) begin errors++; $display("FAIL synchold_dclk cyc %0d got %b exp %b", c, DIV_CLK_OUT, 4'hF); end
      end
      if (c == 20) begin
        checks++; if (CE_OUT !== 4'hC) begin errors++; $display("FAIL syncrel_ce got %b exp %b", CE_OUT, 4'hC); end
        checks++; if (DIV_CLK_OUT !== 4'h2) begin errors++; $display("FAIL syncrel_dclk got %b exp %b", DIV_CLK_OUT, 4'h2); end
      end
      CFG_VALID = (c == 1 || c == 4);
      CFG_CH    = (c == 4) ? 2'd1 : 2'd0;
      CFG_DIV   = (c == 4) ? 16'd7 : 16'd3;
      SYNC      = (c == 9 || c == 17 || c == 18);
      if (c < 20) step();
    end
    CFG_VALID = 1'b0;
    SYNC      = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic exp_rdy, exp_ce3, exp_dc3;
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      if (c >= 2) begin
        exp_rdy = (c == 4 || c >= 8);
        exp_ce3 = (c == 2 || c >= 6);
        exp_dc3 = (c == 3 || c == 4);
        checks++; if (CFG_READY !== exp_rdy) begin errors++; $display("FAIL b2b_ready cyc %0d got %b exp %b", c, CFG_READY, exp_rdy); end
        checks++; if (CE_OUT[3] !== exp_ce3) begin errors++; $display("FAIL b2b_ce3 cyc %0d got %b exp %b", c, CE_OUT[3], exp_ce3); end
        checks++; if (DIV_CLK_OUT[3] !== exp_dc3) begin errors++; $display("FAIL b2b_dclk3 cyc %0d got %b exp %b", c, DIV_CLK_OUT[3], exp_dc3); end
      end
      CFG_VALID = (c <= 4);
      CFG_CH    = 2'd3;
      CFG_DIV   = (c == 1) ? 16'd4 : 16'd1;
      step();
    end
    CFG_VALID = 1'b0;
  endtask

  task automatic test_reset_pending();
    logic [3:0] exp_ce, exp_dc;
    do_reset();
    CFG_VALID = 1'b1;
    CFG_CH    = 2'd1;
    CFG_DIV   = 16'd9;
    step();
    CFG_VALID = 1'b0;
    checks++; if (CFG_READY !== 1'b0) begin errors++; $display("FAIL rp_accept_ready got %b exp 0", CFG_READY); end
    RESET = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++; if (CFG_READY !== 1'b0) begin errors++; $display("FAIL rp_ready in reset %0d got %b exp 0", k, CFG_READY); end
      checks++; if (CE_OUT !== 4'h0) begin errors++; $display("FAIL rp_ce in reset %0d got %b exp %b", k, CE_OUT, 4'h0); end
      checks++; if (DIV_CLK_OUT !== 4'h0) begin errors++; $display("FAIL rp_dclk in reset %0d got %b exp %b", k, DIV_CLK_OUT, 4'h0); end
    end
    RESET = 1'b0;
    step();
    for (int k = 1; k <= 12; k++) begin
      exp_ce = (k % 2 == 0) ? 4'hF : 4'h0;
      exp_dc = (k % 2 == 1) ? 4'hF : 4'h0;
      checks++; if (CE_OUT !== exp_ce) begin errors++; $display("FAIL rp_ce cyc %0d got %b exp %b", k, CE_OUT, exp_ce); end
      checks++; if (DIV_CLK_OUT !== exp_dc) begin errors++; $display("FAIL rp_dclk cyc %0d got %b exp %b", k, DIV_CLK_OUT, exp_dc); end
      checks++; if (CFG_READY !== 1'b1) begin errors++; $display("FAIL rp_ready cyc %0d got %b exp 1", k, CFG_READY); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_ratio_change();
    test_disable_enable();
    test_sync();
    test_back_to_back();
    test_reset_pending();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
